// File: rtl/priority_arbiter_fsm_if.sv
// Requester-side bundle for priority_arbiter_fsm: request/mode inputs and
// registered grant/status outputs.
interface priority_arbiter_fsm_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          mode;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  modport master (
    output mode, req,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  mode, req,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/priority_arbiter_fsm.sv
// Registered N-way arbiter (fixed priority or round-robin) with a hold-time
// limit and a mandatory idle cycle between grants.
module priority_arbiter_fsm #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  priority_arbiter_fsm_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] gnt_id_q;
  logic [IW-1:0] last;
  logic          busy_q;
  logic          timeout_q;
  logic [CW-1:0] hold_cnt;

  logic [IW-1:0] winner;
  logic [IW-1:0] idx;
  logic          found;
  logic          any_req;

  // Fixed mode scans from bit 0; round-robin scans from last+1 with wrap.
  always_comb begin
    any_req = |bus.req;
    winner  = '0;
    found   = 1'b0;
    idx     = '0;
    if (!bus.mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && bus.req[i]) begin
          winner = IW'(i);
          found  = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx = IW'((32'(last) + k) % N);
        if (!found && bus.req[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_cnt  <= '0;
      last      <= IW'(N - 1);
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= BUSY;
            gnt_q    <= N'(1) << winner;
            gnt_id_q <= winner;
            busy_q   <= 1'b1;
            hold_cnt <= CW'(1);
            if (bus.mode) last <= winner;
          end
        end
        BUSY: begin
          // Owner release takes precedence over the hold limit on the same edge.
          if (!bus.req[gnt_id_q] || hold_cnt == CW'(MAX_HOLD)) begin
            state     <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            hold_cnt  <= '0;
            timeout_q <= bus.req[gnt_id_q];
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_priority_arbiter_fsm.sv
// Self-checking bench for priority_arbiter_fsm: vector table, corner-case
// sequences and randomized traffic against a behavioural reference model.
module tb_priority_arbiter_fsm;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IW       = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  priority_arbiter_fsm_if #(.N(N)) bus ();

  priority_arbiter_fsm #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), cycles held, RR pointer.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = N - 1;
  bit m_to    = 1'b0;

  function automatic int pick(input logic m, input logic [N-1:0] r, input int lst);
    int j;
    if (!m) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (lst + k) % N;
        if (r[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input logic rn, input logic m, input logic [N-1:0] r);
    int w;
    if (!rn) begin
      m_owner = -1; m_held = 0; m_last = N - 1; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (r != 0) begin
          w = pick(m, r, m_last);
          m_owner = w;
          m_held  = 1;
          if (m) m_last = w;
        end
      end else if (!r[m_owner]) begin
        m_owner = -1; m_held = 0;
      end else if (m_held == MAX_HOLD) begin
        m_owner = -1; m_held = 0; m_to = 1'b1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N+IW+1:0] dut_vec();
    return {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
  endfunction

  // Drive inputs, clock once, advance model, compare outputs and invariants.
  task automatic step(input logic rn, input logic m, input logic [N-1:0] r);
    logic [N-1:0]  eg;
    logic [IW-1:0] eid;
    logic          inv;
    rst_n   = rn;
    bus.mode = m;
    bus.req  = r;
    @(posedge clk);
    model_step(rn, m, r);
    #1;
    eg  = (m_owner >= 0) ? N'(1) << m_owner : '0;
    eid = (m_owner >= 0) ? IW'(m_owner) : '0;
    check_eq("model", 32'(dut_vec()), 32'({eg, eid, (m_owner >= 0), m_to}));
    inv = ((bus.gnt & (bus.gnt - 1'b1)) == '0) &&
          ((bus.gnt != '0) == bus.busy) &&
          ((bus.gnt == '0) ? (bus.gnt_id == '0) : (bus.gnt == (N'(1) << bus.gnt_id)));
    check_eq("invariant", 32'(inv), 32'd1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic          rn;
    logic          m;
    logic [N-1:0]  r;
    logic [N-1:0]  g;
    logic [IW-1:0] id;
    logic          b;
    logic          to;
  } vec_t;

  vec_t tbl[7];
  int   exp_order[5];
  int   order[$];
  int   to_cnt;
  int   run;
  logic prev_busy;
  logic cur_mode;
  logic [N-1:0] cur_req;

  initial begin
    rst_n    = 1'b0;
    bus.mode = 1'b0;
    bus.req  = '0;

    // Grant latency, release, dead cycle, next grant.
    tbl[0] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rn, tbl[i].m, tbl[i].r);
      check_eq($sformatf("tbl%0d", i), 32'(dut_vec()),
               32'({tbl[i].g, tbl[i].id, tbl[i].b, tbl[i].to}));
    end

    // Round-robin with continuous full request: 0,1,2,3,0 each held MAX_HOLD.
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    to_cnt = 0; run = 0; prev_busy = 1'b0;
    for (int c = 0; c < 45; c++) begin
      step(1'b1, 1'b1, 4'b1111);
      if (bus.timeout) to_cnt++;
      if (bus.busy && !prev_busy) order.push_back(int'(bus.gnt_id));
      if (bus.busy) run++;
      else if (run > 0) begin
        check_eq("rr_hold_len", 32'(run), 32'(MAX_HOLD));
        run = 0;
      end
      prev_busy = bus.busy;
    end
    check_eq("rr_timeouts", 32'(to_cnt), 32'd5);
    check_eq("rr_grants", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check_eq($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // Fixed mode timeout and re-grant; late req[3] does not steal the grant.
    do_reset();
    step(1'b1, 1'b0, 4'b0001);
    check_eq("fx_grant", 32'(bus.gnt), 32'b0001);
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 1'b0, 4'b1001);
      check_eq("fx_owner", 32'(bus.gnt), 32'b0001);
    end
    step(1'b1, 1'b0, 4'b1001);
    check_eq("fx_timeout", 32'({bus.gnt, bus.timeout}), 32'({4'b0000, 1'b1}));
    step(1'b1, 1'b0, 4'b1001);
    check_eq("fx_regrant", 32'({bus.gnt, bus.timeout}), 32'({4'b0001, 1'b0}));

    // Release on the same edge the hold limit is reached: no timeout.
    do_reset();
    step(1'b1, 1'b0, 4'b0001);
    for (int c = 0; c < 7; c++) step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 4'b0000);
    check_eq("edge_release", 32'({bus.gnt, bus.busy, bus.timeout}), 32'({4'b0000, 1'b0, 1'b0}));

    // Reset mid-grant, then RR pointer restarts at N-1.
    do_reset();
    step(1'b1, 1'b0, 4'b0100);
    check_eq("rst_pre", 32'(bus.gnt), 32'b0100);
    step(1'b0, 1'b0, 4'b1100);
    check_eq("rst_drop", 32'({bus.gnt, bus.busy}), 32'({4'b0000, 1'b0}));
    step(1'b1, 1'b1, 4'b1100);
    check_eq("rst_rr", 32'({bus.gnt, bus.gnt_id}), 32'({4'b0100, 2'd2}));

    // Mode change during a grant only matters at the next arbitration.
    do_reset();
    step(1'b1, 1'b1, 4'b0001);
    step(1'b1, 1'b1, 4'b0000);
    step(1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 4'b0011);
    check_eq("mode_fx_grant", 32'(bus.gnt), 32'b0001);
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 1'b1, 4'b0011);
      check_eq("mode_owner", 32'(bus.gnt), 32'b0001);
    end
    step(1'b1, 1'b1, 4'b0011);
    check_eq("mode_timeout", 32'(bus.timeout), 32'd1);
    step(1'b1, 1'b1, 4'b0011);
    check_eq("mode_rr_grant", 32'(bus.gnt), 32'b0010);

    // Randomized traffic with sticky requests so holds reach the limit.
    do_reset();
    cur_mode = 1'b0;
    cur_req  = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = ~cur_mode;
      if ($urandom_range(0, 1) == 0) cur_req = N'($urandom);
      step(($urandom_range(0, 199) != 0), cur_mode, cur_req);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
